// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and a byte-addressed data memory port.
// Halfword and misaligned word accesses are broken into byte beats; loads are assembled and extended.
module mem_access_ctrl #(
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [2:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] CmdLw  = 3'b000;
    localparam logic [2:0] CmdLbu = 3'b110;
    localparam logic [2:0] CmdSw  = 3'b001;
    localparam logic [2:0] CmdSb  = 3'b011;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        word_q, word_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] buf_q, buf_d;
    logic        err_q, err_d;

    logic        req_aligned;
    logic        req_err;
    logic [1:0]  req_last;

    // Request decode, only meaningful while idle.
    always_comb begin
        req_aligned = (req_addr[1:0] == 2'b00);
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
            req_err = 1'b1;
        end
        if (req_write && req_funct3[2]) begin
            req_err = 1'b1;
        end
        if (req_funct3 == 3'b010 && !req_aligned && SPLIT_MISALIGNED == 0) begin
            req_err = 1'b1;
        end
        case (req_funct3[1:0])
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            2'b10:   req_last = req_aligned ? 2'd0 : 2'd3;
            default: req_last = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        last_d     = last_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        busy       = (state_q != StIdle);
        mem_we     = CmdLw;
        mem_addr   = 32'h0;
        mem_wd     = 32'h0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    word_d   = (req_funct3 == 3'b010) && req_aligned;
                    last_d   = req_last;
                    beat_d   = 2'd0;
                    buf_d    = 32'h0;
                    err_d    = req_err;
                    state_d  = req_err ? StResp : StAccess;
                end
            end

            StAccess: begin
                if (word_q) begin
                    mem_we   = write_q ? CmdSw : CmdLw;
                    mem_addr = addr_q;
                    mem_wd   = wdata_q;
                    if (!write_q) begin
                        buf_d = mem_rd;
                    end
                end else begin
                    // Byte beats always read zero-extended; extension happens at response time.
                    mem_we   = write_q ? CmdSb : CmdLbu;
                    mem_addr = addr_q + {30'h0, beat_q};
                    mem_wd   = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
                    if (!write_q) begin
                        buf_d[{beat_q, 3'b000} +: 8] = mem_rd[7:0];
                    end
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == last_q) begin
                    state_d = StResp;
                end
            end

            StResp: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !write_q) begin
                    case (funct3_q)
                        3'b000:  resp_rdata = {{24{buf_q[7]}}, buf_q[7:0]};
                        3'b100:  resp_rdata = {24'h0, buf_q[7:0]};
                        3'b001:  resp_rdata = {{16{buf_q[15]}}, buf_q[15:0]};
                        3'b101:  resp_rdata = {16'h0, buf_q[15:0]};
                        3'b010:  resp_rdata = buf_q;
                        default: resp_rdata = 32'h0;
                    endcase
                end
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= 3'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 1'b0;
            last_q   <= 2'd0;
            beat_q   <= 2'd0;
            buf_q    <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random requests
// checked against a byte-array reference model of load/store semantics.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [2:0]  mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    // Second instance with misaligned words disallowed; its memory port is never expected to be used.
    logic        req_valid0, req_ready0, resp_valid0, resp_err0, busy0;
    logic [31:0] resp_rdata0, mem_addr0, mem_wd0;
    logic [2:0]  mem_we0;
    logic [31:0] mem_rd0 = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:1023];
    logic [7:0] ref_mem [0:1023];
    int         wr_cmds = 0;
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = 10'h0;
    logic [7:0] bd_data = 8'h0;
    logic [9:0] ra;

    always #5 clk = ~clk;

    mem_access_ctrl #(.SPLIT_MISALIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_access_ctrl #(.SPLIT_MISALIGNED(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(1'b0), .req_funct3(3'b010), .req_addr(32'h2),
        .req_wdata(32'h0), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .busy(busy0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wd(mem_wd0), .mem_rd(mem_rd0)
    );

    // Memory model: asynchronous read, writes on the clock edge.
    always_comb begin
        ra = mem_addr[9:0];
        case (mem_we)
            3'b000:  mem_rd = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
            3'b010:  mem_rd = {{24{mem[ra][7]}}, mem[ra]};
            3'b110:  mem_rd = {24'h0, mem[ra]};
            default: mem_rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_we == 3'b001) begin
            mem[mem_addr[9:0]]         <= mem_wd[7:0];
            mem[mem_addr[9:0] + 10'd1] <= mem_wd[15:8];
            mem[mem_addr[9:0] + 10'd2] <= mem_wd[23:16];
            mem[mem_addr[9:0] + 10'd3] <= mem_wd[31:24];
            wr_cmds <= wr_cmds + 1;
        end else if (mem_we == 3'b011) begin
            mem[mem_addr[9:0]] <= mem_wd[7:0];
            wr_cmds <= wr_cmds + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_addr = a[9:0];
        bd_data = d;
        ref_mem[a[9:0]] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    function automatic bit model_err(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                     input bit split);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (wr && f3 >= 3'd4) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0 && !split) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_bytes(input logic [2:0] f3);
        if (f3 == 3'd2) return 4;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 1;
    endfunction

    // Memory commands: aligned word is one command, everything else is one per byte.
    function automatic int model_cmds(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd2 && (a % 4) == 0) return 1;
        return model_bytes(f3);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int n = model_bytes(f3);
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai = a + 32'(i);
            v = v | (32'(ref_mem[ai[9:0]]) << (8 * i));
        end
        case (f3)
            3'd0:    return (v[7] ? 32'hFFFFFF00 : 32'h0) | v;
            3'd1:    return (v[15] ? 32'hFFFF0000 : 32'h0) | v;
            default: return v;
        endcase
    endfunction

    task automatic do_req(input string tag, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          e = model_err(wr, f3, a, 1'b1);
        int          exp_lat = e ? 1 : model_cmds(f3, a) + 1;
        int          exp_wr = (wr && !e) ? model_cmds(f3, a) : 0;
        logic [31:0] exp_rd = (wr || e) ? 32'h0 : model_load(f3, a);
        int          w0, lat;
        bit          got = 1'b0;
        logic [31:0] rd = 32'h0;
        logic        er = 1'b0;

        @(negedge clk);
        check({tag, ".ready_idle"}, req_ready, 1'b1);
        req_write = wr;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        w0 = wr_cmds;
        lat = 0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            check({tag, ".busy_stall"}, {busy, req_ready}, 2'b10);
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        check({tag, ".resp_seen"}, got, 1'b1);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, er, e);
        check({tag, ".write_cmds"}, wr_cmds - w0, exp_wr);
        if (wr && !e) begin
            for (int i = 0; i < model_bytes(f3); i++) begin
                logic [31:0] ai = a + 32'(i);
                ref_mem[ai[9:0]] = wd[8 * i +: 8];
            end
        end
    endtask

    initial begin
        int          pulses;
        int          ptime [3];
        logic [2:0]  f3set [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'h0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_valid0 = 1'b0;
        #1;
        check("reset_outputs", {req_ready, resp_valid, resp_rdata, resp_err, busy, mem_we,
                                mem_addr, mem_wd}, {1'b1, 102'h0});
        check("reset_outputs0", {req_ready0, resp_valid0, busy0, mem_we0}, {1'b1, 5'h0});

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            bd_we = 1'b1;
            bd_addr = 10'(i);
            bd_data = 8'($urandom);
            ref_mem[i] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
        rst_n = 1'b1;

        do_req("sw_aligned", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        do_req("lw_aligned", 1'b0, 3'd2, 32'h100, 32'h0);
        check("lw_value", model_load(3'd2, 32'h100), 32'hDEADBEEF);

        bd_write(32'h101, 8'h34);
        bd_write(32'h102, 8'h84);
        do_req("lh", 1'b0, 3'd1, 32'h101, 32'h0);
        check("lh_value", model_load(3'd1, 32'h101), 32'hFFFF8434);
        do_req("lhu", 1'b0, 3'd5, 32'h101, 32'h0);

        do_req("sw_split", 1'b1, 3'd2, 32'h203, 32'h11223344);
        do_req("lw_split", 1'b0, 3'd2, 32'h203, 32'h0);

        do_req("ld_f3_011", 1'b0, 3'd3, 32'h40, 32'h0);
        do_req("st_f3_101", 1'b1, 3'd5, 32'h40, 32'h55AA55AA);

        @(negedge clk);
        req_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        check("nosplit_lw_err", {resp_valid0, resp_err0, resp_rdata0}, {2'b11, 32'h0});
        @(negedge clk);
        check("nosplit_idle", {busy0, req_ready0}, 2'b01);

        // Reset during the third beat of a split store.
        @(negedge clk);
        req_write = 1'b1;
        req_funct3 = 3'd2;
        req_addr = 32'h301;
        req_wdata = 32'hAABBCCDD;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_beat2", {mem_we, mem_addr, mem_wd}, {3'b011, 32'h303, 32'hBB});
        rst_n = 1'b0;
        #1;
        check("abort_reset_outputs", {req_ready, resp_valid, resp_rdata, resp_err, busy, mem_we,
                                      mem_addr, mem_wd}, {1'b1, 102'h0});
        ref_mem[10'h301] = 8'hDD;
        ref_mem[10'h302] = 8'hCC;
        @(negedge clk);
        rst_n = 1'b1;
        do_req("abort_readback", 1'b0, 3'd2, 32'h301, 32'h0);

        // Back-to-back loads with req_valid held.
        bd_write(32'h50, 8'h80);
        @(negedge clk);
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h50;
        req_valid = 1'b1;
        pulses = 0;
        ptime = '{0, 0, 0};
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check("b2b_ready_vs_busy", busy & req_ready, 1'b0);
            if (resp_valid) begin
                check("b2b_rdata", resp_rdata, 32'hFFFFFF80);
                ptime[pulses] = i;
                pulses++;
                if (pulses == 3) begin
                    req_valid = 1'b0;
                    break;
                end
            end
        end
        check("b2b_pulses", pulses, 3);
        check("b2b_times", {ptime[0], ptime[1], ptime[2]}, {32'd2, 32'd5, 32'd8});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_quiet", {resp_valid, busy}, 2'b00);
        end

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            do_req("rand", 1'($urandom), f3set[$urandom_range(0, 7)], a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
